// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter: two-master Wishbone B3 arbiter for the shared SDRAM port.
// m0 (screen DMA) has priority, a starved m1 outranks it, hung cycles abort with ERR.
module wb_sdram_arbiter #(
   parameter int AW      = 24,
   parameter int DW      = 32,
   parameter int STARVE  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            m0_cyc,
   input  logic            m0_stb,
   input  logic            m0_we,
   input  logic [AW-1:0]   m0_adr,
   input  logic [DW-1:0]   m0_dat_w,
   input  logic [DW/8-1:0] m0_sel,
   output logic            m0_ack,
   output logic            m0_err,
   input  logic            m1_cyc,
   input  logic            m1_stb,
   input  logic            m1_we,
   input  logic [AW-1:0]   m1_adr,
   input  logic [DW-1:0]   m1_dat_w,
   input  logic [DW/8-1:0] m1_sel,
   output logic            m1_ack,
   output logic            m1_err,
   output logic [DW-1:0]   m_dat_r,
   output logic            s_cyc,
   output logic            s_stb,
   output logic            s_we,
   output logic [AW-1:0]   s_adr,
   output logic [DW-1:0]   s_dat_w,
   output logic [DW/8-1:0] s_sel,
   input  logic            s_ack,
   input  logic [DW-1:0]   s_dat_r,
   output logic [1:0]      gnt
);

   localparam int WCW = $clog2(STARVE + 1);
   localparam int TCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

   state_t         state;
   state_t         state_nxt;
   state_t         arb;
   logic           own;
   logic           owning;
   logic           o_cyc;
   logic           o_stb;
   logic           stall;
   logic           starve;
   logic           to_hit;
   logic [WCW-1:0] wait_cnt;
   logic [TCW-1:0] to_cnt;

   assign starve = (wait_cnt == WCW'(STARVE));

   // A releasing master has cyc=0 here, so it never competes for its own handoff
   assign arb = (m1_cyc && (starve || !m0_cyc)) ? OWN1 :
                m0_cyc                          ? OWN0 : IDLE;

   assign owning = (state == OWN0) || (state == OWN1);
   assign o_cyc  = own ? m1_cyc : m0_cyc;
   assign o_stb  = own ? m1_stb : m0_stb;

   assign s_cyc   = owning & o_cyc;
   assign s_stb   = s_cyc & o_stb;
   assign s_we    = s_cyc & (own ? m1_we : m0_we);
   assign s_adr   = owning ? (own ? m1_adr : m0_adr) : '0;
   assign s_dat_w = owning ? (own ? m1_dat_w : m0_dat_w) : '0;
   assign s_sel   = owning ? (own ? m1_sel : m0_sel) : '0;
   assign m_dat_r = s_dat_r;

   assign m0_ack = owning & ~own & s_stb & s_ack;
   assign m1_ack = owning &  own & s_stb & s_ack;
   assign m0_err = (state == ABORT) & ~own & m0_stb;
   assign m1_err = (state == ABORT) &  own & m1_stb;

   assign gnt = (state == IDLE) ? 2'b00 : (own ? 2'b10 : 2'b01);

   assign stall  = s_stb & ~s_ack;
   assign to_hit = (TIMEOUT != 0) && stall &&
                   (to_cnt == TCW'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: state_nxt = arb;
         OWN0, OWN1: begin
            if (!o_cyc)
               state_nxt = arb;
            else if (to_hit)
               state_nxt = ABORT;
         end
         ABORT: begin
            if (!o_cyc)
               state_nxt = arb;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         own      <= 1'b0;
         wait_cnt <= '0;
         to_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt == OWN0)
            own <= 1'b0;
         else if (state_nxt == OWN1)
            own <= 1'b1;
         to_cnt <= stall ? to_cnt + TCW'(1) : '0;
         if (!m1_cyc || state_nxt == OWN1)
            wait_cnt <= '0;
         else if (gnt != 2'b10 && !starve)
            wait_cnt <= wait_cnt + WCW'(1);
      end
   end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb_wb_sdram_arbiter: scenario tasks with a read-data scoreboard
// for the two-master SDRAM Wishbone arbiter.
module tb_wb_sdram_arbiter;

   localparam int AW = 24;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_cyc, m0_stb, m0_we;
   logic [AW-1:0] m0_adr;
   logic [DW-1:0] m0_dat_w;
   logic [SW-1:0] m0_sel;
   logic          m0_ack, m0_err;
   logic          m1_cyc, m1_stb, m1_we;
   logic [AW-1:0] m1_adr;
   logic [DW-1:0] m1_dat_w;
   logic [SW-1:0] m1_sel;
   logic          m1_ack, m1_err;
   logic [DW-1:0] m_dat_r;
   logic          s_cyc, s_stb, s_we;
   logic [AW-1:0] s_adr;
   logic [DW-1:0] s_dat_w;
   logic [SW-1:0] s_sel;
   logic          s_ack;
   logic [DW-1:0] s_dat_r;
   logic [1:0]    gnt;

   int checks = 0;
   int errors = 0;
   logic [32:0] sb_q[$];

   // Slave returns a tag plus its address so each beat's data is distinct
   assign s_dat_r = {8'hC3, s_adr};

   always #5 clk = ~clk;

   wb_sdram_arbiter #(
      .AW(AW), .DW(DW), .STARVE(64), .TIMEOUT(255)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
      .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel),
      .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
      .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel),
      .m1_ack(m1_ack), .m1_err(m1_err),
      .m_dat_r(m_dat_r),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
      .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
      .s_ack(s_ack), .s_dat_r(s_dat_r),
      .gnt(gnt)
   );

   task automatic drive_idle();
      m0_cyc = 0; m0_stb = 0; m0_we = 0;
      m0_adr = '0; m0_dat_w = '0; m0_sel = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0;
      m1_adr = '0; m1_dat_w = '0; m1_sel = '0;
      s_ack = 0;
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      drive_idle();
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      m0_cyc = 1; m0_stb = 1;
      m1_cyc = 1; m1_stb = 1;
      s_ack = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (gnt !== 2'b00) begin
         errors++;
         $display("FAIL rst_gnt got %b want 00", gnt);
      end
      checks++;
      if ({s_cyc, s_stb, s_we} !== 3'b000) begin
         errors++;
         $display("FAIL rst_s got %b want 000",
                  {s_cyc, s_stb, s_we});
      end
      checks++;
      if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_ack_err got %b want 0000",
                  {m0_ack, m0_err, m1_ack, m1_err});
      end
      checks++;
      if (dut.wait_cnt !== 7'd0 || dut.to_cnt !== 8'd0) begin
         errors++;
         $display("FAIL rst_cnt got %0d/%0d want 0/0",
                  dut.wait_cnt, dut.to_cnt);
      end
      drive_idle();
      rst_n = 1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
         errors++;
         $display("FAIL rst_idle got gnt=%b s_cyc=%b want 00/0",
                  gnt, s_cyc);
      end
   endtask

   task automatic test_m0_burst();
      int acks = 0;
      int a1 = 0;
      logic [32:0] e;
      @(posedge clk); #1;
      m0_cyc = 1; m0_stb = 1; m0_we = 0;
      m0_adr = 24'h000100;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b00) begin
         errors++;
         $display("FAIL t1_pre_gnt got %b want 00", gnt);
      end
      @(posedge clk); #1;
      s_ack = 1;
      for (int c = 0; c < 12 && acks < 4; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         m0_adr = 24'h000100 + 24'(acks);
         if (sb_q.size() == 0)
            sb_q.push_back({1'b0, 8'hC3, m0_adr});
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (gnt !== 2'b01) begin
               errors++;
               $display("FAIL t1_gnt got %b want 01", gnt);
            end
         end
         if (m1_ack === 1'b1) a1++;
         if (m0_ack === 1'b1) begin
            e = sb_q.pop_front();
            checks++;
            if ({1'b0, m_dat_r} !== e) begin
               errors++;
               $display("FAIL t1_data got %h want %h",
                        m_dat_r, e[31:0]);
            end
            acks++;
         end
      end
      checks++;
      if (acks != 4) begin
         errors++;
         $display("FAIL t1_ack_count got %0d want 4", acks);
      end
      checks++;
      if (a1 != 0) begin
         errors++;
         $display("FAIL t1_m1_ack got %0d want 0", a1);
      end
      @(posedge clk); #1;
      m0_cyc = 0; m0_stb = 0; s_ack = 0;
      @(negedge clk);
      checks++;
      if (s_cyc !== 1'b0) begin
         errors++;
         $display("FAIL t1_release got s_cyc=%b want 0", s_cyc);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b00) begin
         errors++;
         $display("FAIL t1_idle got %b want 00", gnt);
      end
      go_idle();
   endtask

   task automatic test_handoff();
      int acks = 0;
      logic [32:0] e;
      @(posedge clk); #1;
      m0_cyc = 1; m0_stb = 1; m0_adr = 24'h000200;
      m1_cyc = 1; m1_stb = 1; m1_adr = 24'h000300;
      @(posedge clk); #1;
      s_ack = 1;
      for (int c = 0; c < 12 && acks < 3; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         m0_adr = 24'h000200 + 24'(acks);
         if (sb_q.size() == 0)
            sb_q.push_back({1'b0, 8'hC3, m0_adr});
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (gnt !== 2'b01) begin
               errors++;
               $display("FAIL t2_gnt0 got %b want 01", gnt);
            end
         end
         checks++;
         if (m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL t2_m1_early got %b want 0", m1_ack);
         end
         if (m0_ack === 1'b1) begin
            e = sb_q.pop_front();
            checks++;
            if ({1'b0, m_dat_r} !== e) begin
               errors++;
               $display("FAIL t2_m0_data got %h want %h",
                        m_dat_r, e[31:0]);
            end
            acks++;
         end
      end
      @(posedge clk); #1;
      m0_cyc = 0; m0_stb = 0;
      @(negedge clk);
      checks++;
      if (s_cyc !== 1'b0 || gnt !== 2'b01) begin
         errors++;
         $display("FAIL t2_gap got s_cyc=%b gnt=%b want 0/01",
                  s_cyc, gnt);
      end
      @(posedge clk); #1;
      sb_q.push_back({1'b1, 8'hC3, m1_adr});
      @(negedge clk);
      checks++;
      if (gnt !== 2'b10) begin
         errors++;
         $display("FAIL t2_gnt1 got %b want 10", gnt);
      end
      checks++;
      if (s_adr !== 24'h000300 || s_cyc !== 1'b1) begin
         errors++;
         $display("FAIL t2_adr got %h/%b want 000300/1",
                  s_adr, s_cyc);
      end
      checks++;
      if (m1_ack !== 1'b1) begin
         errors++;
         $display("FAIL t2_m1_ack got %b want 1", m1_ack);
      end else begin
         e = sb_q.pop_front();
         checks++;
         if ({1'b1, m_dat_r} !== e) begin
            errors++;
            $display("FAIL t2_m1_data got %h want %h",
                     m_dat_r, e[31:0]);
         end
      end
      go_idle();
   endtask

   task automatic test_starve();
      @(posedge clk); #1;
      m0_cyc = 1;
      @(posedge clk); #1;
      m1_cyc = 1; m1_adr = 24'h000600;
      repeat (70) @(posedge clk);
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL t3_hold got %b want 01", gnt);
      end
      checks++;
      if (dut.wait_cnt !== 7'd64) begin
         errors++;
         $display("FAIL t3_sat got %0d want 64", dut.wait_cnt);
      end
      @(posedge clk); #1;
      m0_cyc = 0;
      @(posedge clk); #1;
      m0_cyc = 1;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b10) begin
         errors++;
         $display("FAIL t3_gnt got %b want 10", gnt);
      end
      checks++;
      if (dut.wait_cnt !== 7'd0) begin
         errors++;
         $display("FAIL t3_clear got %0d want 0", dut.wait_cnt);
      end
      checks++;
      if (s_adr !== 24'h000600) begin
         errors++;
         $display("FAIL t3_adr got %h want 000600", s_adr);
      end
      @(posedge clk); #1;
      m1_cyc = 0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL t3_back got %b want 01", gnt);
      end
      go_idle();
   endtask

   task automatic test_timeout();
      int hit = 0;
      @(posedge clk); #1;
      m1_cyc = 1; m1_stb = 1; m1_we = 0;
      m1_adr = 24'h000400; s_ack = 0;
      for (int c = 1; c <= 300 && hit == 0; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (s_cyc !== 1'b1) hit = c;
      end
      checks++;
      if (hit != 256) begin
         errors++;
         $display("FAIL t4_abort_cycle got %0d want 256", hit);
      end
      checks++;
      if (m1_err !== 1'b1 || m1_ack !== 1'b0 || gnt !== 2'b10) begin
         errors++;
         $display("FAIL t4_err got err=%b ack=%b gnt=%b want 1/0/10",
                  m1_err, m1_ack, gnt);
      end
      @(posedge clk); #1;
      s_ack = 1;
      @(negedge clk);
      checks++;
      if ({m0_ack, m1_ack} !== 2'b00 || m1_err !== 1'b1) begin
         errors++;
         $display("FAIL t4_late_ack got ack=%b err=%b want 00/1",
                  {m0_ack, m1_ack}, m1_err);
      end
      @(posedge clk); #1;
      m1_cyc = 0; m1_stb = 0;
      @(negedge clk);
      checks++;
      if (m1_err !== 1'b0) begin
         errors++;
         $display("FAIL t4_err_drop got %b want 0", m1_err);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b00 || {m0_ack, m1_ack} !== 2'b00) begin
         errors++;
         $display("FAIL t4_idle got gnt=%b ack=%b want 00/00",
                  gnt, {m0_ack, m1_ack});
      end
      go_idle();
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      m1_cyc = 1; m1_stb = 1; m1_we = 1;
      m1_adr = 24'h000500; m1_dat_w = 32'h11112222;
      m1_sel = 4'hF; s_ack = 1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (m1_ack !== 1'b1) begin
         errors++;
         $display("FAIL t5_beat got %b want 1", m1_ack);
      end
      @(posedge clk); #1;
      m1_adr = 24'h000501;
      #2 rst_n = 0;
      #1;
      checks++;
      if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
         errors++;
         $display("FAIL t5_async got gnt=%b s_cyc=%b want 00/0",
                  gnt, s_cyc);
      end
      checks++;
      if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin
         errors++;
         $display("FAIL t5_ack got %b want 0000",
                  {m0_ack, m1_ack, m0_err, m1_err});
      end
      drive_idle();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      m0_cyc = 1; m1_cyc = 1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL t5_post got %b want 01", gnt);
      end
      go_idle();
   endtask

   task automatic test_mux();
      logic [32:0] e;
      logic [62:0] got;
      logic [62:0] want;
      want = {3'b111, 24'h00ABCD, 4'b0011, 32'hDEADBEEF};
      @(posedge clk); #1;
      m1_cyc = 1; m1_stb = 1; m1_we = 1;
      m1_adr = 24'h00ABCD; m1_sel = 4'b0011;
      m1_dat_w = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         m0_cyc = 1;
         m0_stb = i[0];
         m0_we = ~i[0];
         m0_adr = 24'($urandom);
         m0_sel = 4'hC;
         m0_dat_w = $urandom;
         s_ack = (i == 3);
         if (i == 3)
            sb_q.push_back({1'b1, 8'hC3, 24'h00ABCD});
         @(negedge clk);
         got = {s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL t6_mux got %h want %h", got, want);
         end
         checks++;
         if (gnt !== 2'b10 || m0_ack !== 1'b0 || m0_err !== 1'b0) begin
            errors++;
            $display("FAIL t6_m0 got gnt=%b ack=%b err=%b want 10/0/0",
                     gnt, m0_ack, m0_err);
         end
      end
      checks++;
      if (m1_ack !== 1'b1) begin
         errors++;
         $display("FAIL t6_ack got %b want 1", m1_ack);
      end else begin
         e = sb_q.pop_front();
         checks++;
         if ({1'b1, m_dat_r} !== e) begin
            errors++;
            $display("FAIL t6_data got %h want %h",
                     m_dat_r, e[31:0]);
         end
      end
      @(posedge clk); #1;
      m1_cyc = 0; m1_stb = 0; s_ack = 0;
      @(negedge clk);
      checks++;
      if (s_cyc !== 1'b0) begin
         errors++;
         $display("FAIL t6_gap got %b want 0", s_cyc);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL t6_handoff got %b want 01", gnt);
      end
      go_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      drive_idle();
      rst_n = 0;
      test_reset();
      test_m0_burst();
      test_handoff();
      test_starve();
      test_timeout();
      test_reset_mid();
      test_mux();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
